io_uart_tx: RTL
===============

# io_uart_tx

Memory-mapped UART transmitter that answers the CPU's IO interface: the responder on the `io_*` signals driven by the datapath's address decoder. The CPU writes bytes into a small transmit FIFO, and a baud-rate FSM serialises them onto `tx` as 8N1 frames. Register reads are combinational, so a load completes in the CPU's single cycle. Register writes take effect on the rising clock edge.

## Interface
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two, at least 2.
- `CLKS_PER_BIT`, 434: reset value of BAUD_DIV (50 MHz / 115200).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `io_address` in 32: byte address. Only bits [3:2] are decoded; upstream decode guarantees selection.
- `io_write_value` in 32: store data.
- `io_read_value` out 32: load data; combinational; 0 when `io_read_en` is low.
- `io_write_en` in 1: store strobe, one cycle per store.
- `io_read_en` in 1: load strobe; reads have no side effects.
- `io_data_size` in 3: funct3 encoding (0 b, 1 h, 2 w, 4 bu, 5 hu). Ignored except as noted below.
- `tx` out 1: serial line, idle high.
- `irq` out 1: high when CTRL.irq_en = 1 and the FIFO is empty.

## Operation
Register map, by `io_address[3:2]`:
- **0 TXDATA (W)**
  - Write pushes `io_write_value[7:0]` for any size.
  - Write when full: data dropped and STATUS.ovf set.
  - Reads return 0.
- **1 STATUS (R/W1C)**
  - Bit 0: busy (FSM not IDLE).
  - Bit 1: full.
  - Bit 2: empty.
  - Bit 3: ovf (sticky).
  - Bits [15:8]: FIFO count.
  - Writing 1 to bit 3 clears ovf. All other bits are read-only.
- **2 BAUD_DIV (RW)**
  - Bits [15:0] hold the clocks per bit; upper bits read 0.
  - A value of 0 or 1 behaves as 1.
- **3 CTRL (RW)**
  - Bit 0: tx_en.
  - Bit 1: irq_en.

Reset values:
- FIFO empty; ovf = 0; BAUD_DIV = `CLKS_PER_BIT`; CTRL = 0b01.
- FSM in IDLE; `tx` = 1; `irq` = 0; bit counter = 0; baud counter = 0.

FSM states and transitions:
- **IDLE**: `tx` = 1. If tx_en = 1 and the FIFO is non-empty, pop the head into the shift register, go to START, and clear the baud counter.
- **START**: `tx` = 0 for one bit time, then go to DATA with bit index 0.
- **DATA**: `tx` = shift[0], LSB first. At each bit end, shift right and increment the index. After index 7, go to STOP.
- **STOP**: `tx` = 1 for one bit time, then go to IDLE.

Bit timing:
- The baud counter counts 0..div-1, where div = max(BAUD_DIV, 1).
- The bit ends when the counter is at least div-1. This makes a mid-frame shrink of BAUD_DIV end the current bit on the next cycle.
- BAUD_DIV writes apply immediately to the live comparison.
- Clearing tx_en mid-frame finishes the current frame. It only blocks the next pop.

Boundary conditions:
- **Push and pop in the same cycle with the FIFO full**: the push is accepted, count is unchanged, and ovf is not set.
- **Push and pop in the same cycle with the FIFO empty**: impossible, because a pop requires non-empty as sampled at the start of the cycle.
- **Read and write in the same cycle**: the read returns the pre-edge value.
- **Pointers**: log2(`FIFO_DEPTH`) bits, wrapping modulo the depth. Count is log2+1 bits.
- **Reset mid-frame**: `tx` returns high on the next edge and queued data is discarded.

## Timing
- **Write to TXDATA at edge N** (FIFO empty, IDLE, tx_en = 1): count = 1 after edge N. Pop at edge N+1; `tx` low from after edge N+1.
- **Frame length**: exactly 10·div cycles, start through stop.
- **Back-to-back frames**: the next START begins one cycle after STOP ends (the IDLE pop cycle). Frame period is 10·div+1 cycles.
- **`io_read_value`**: zero-latency combinational path from `io_address` and the register state.
- **`irq`**: registered-state derived, with no extra latency beyond the state change.

## Structure
- Shared package/header `io_uart_pkg`:
  - Register offsets (0x0/0x4/0x8/0xC).
  - STATUS bit positions.
  - CTRL bit positions.
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Ports: push, pop, din, dout, full, empty, count.
  - Same-cycle push/pop semantics as above.
- The top level holds the register file, read mux, baud counter and FSM.

## Test plan
- Reset, then read all four registers:
  - STATUS = 0x0000_0004, BAUD_DIV = 434, CTRL = 0x1.
  - `tx` = 1 and `irq` = 0 throughout.
- BAUD_DIV = 4, write TXDATA 0xA5:
  - `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles.
  - Total 40 cycles; busy clears afterwards.
- Set tx_en = 0 and write 9 bytes with `FIFO_DEPTH` = 8:
  - STATUS shows full = 1, count = 8, ovf = 1.
  - Write STATUS 0x8: ovf = 0.
  - Set tx_en = 1: all 8 bytes go out in order, 1 idle cycle between frames.
- FIFO full while the FSM pops, write 0x3C in the same cycle:
  - Accepted, ovf stays 0, 0x3C is transmitted last.
- BAUD_DIV = 100, mid-bit write BAUD_DIV = 2:
  - The current bit ends on the next cycle; later bits last 2 cycles.
- Assert `reset` during the DATA state:
  - `tx` = 1 and STATUS = 0x4 after the edge; no further frames.
- irq_en = 1 with an empty FIFO: `irq` = 1.
  - After a TXDATA write, `irq` drops the next cycle and rises again when the pop empties the FIFO.

Source files
------------

// File: rtl/io_uart_pkg.sv
// Shared register map, bit positions and FSM encoding for the memory-mapped UART transmitter.
package io_uart_pkg;

  localparam logic [3:0] REG_TXDATA_OFF = 4'h0;
  localparam logic [3:0] REG_STATUS_OFF = 4'h4;
  localparam logic [3:0] REG_BAUD_OFF   = 4'h8;
  localparam logic [3:0] REG_CTRL_OFF   = 4'hC;

  localparam logic [1:0] REG_TXDATA = REG_TXDATA_OFF[3:2];
  localparam logic [1:0] REG_STATUS = REG_STATUS_OFF[3:2];
  localparam logic [1:0] REG_BAUD   = REG_BAUD_OFF[3:2];
  localparam logic [1:0] REG_CTRL   = REG_CTRL_OFF[3:2];

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 8;

  localparam int CTRL_TX_EN_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A divider of 0 would never let a bit end, so 0 and 1 both mean one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div <= 16'd1) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/io_uart_tx_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, combinational read mux, baud counter and frame FSM.
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_value,
  output logic [31:0] io_read_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [2:0]  io_data_size,
  output logic        tx,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [15:0]      baud_cnt_q, baud_cnt_d;
  logic             tx_q, tx_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [15:0]      baud_div_q, baud_div_d;
  logic             ovf_q, ovf_d;

  logic [1:0]       reg_idx_s;
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             start_s;
  logic             bit_end_s;
  logic [15:0]      div_eff_s;
  logic [31:0]      status_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign reg_idx_s   = io_address[3:2];
  assign fifo_push_s = io_write_en && (reg_idx_s == REG_TXDATA);
  assign start_s     = ctrl_q[CTRL_TX_EN_BIT] && !fifo_empty_s;
  assign div_eff_s   = eff_div(baud_div_q);
  // ">=" rather than "==" so a divider shrunk below the running count ends the bit at once.
  assign bit_end_s   = (baud_cnt_q >= (div_eff_s - 16'd1));
  assign unused_s    = ^{io_data_size, io_address[31:4], io_address[1:0], io_write_value[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (io_write_value[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Register-file write decode.
  always_comb begin
    ctrl_d     = ctrl_q;
    baud_div_d = baud_div_q;
    ovf_d      = ovf_q;
    if (io_write_en) begin
      case (reg_idx_s)
        REG_TXDATA: begin
          if (fifo_full_s && !fifo_pop_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end
        REG_STATUS: begin
          if (io_write_value[STATUS_OVF_BIT]) begin
            ovf_d = 1'b0;
          end else begin
            ovf_d = ovf_q;
          end
        end
        REG_BAUD: baud_div_d = io_write_value[15:0];
        REG_CTRL: ctrl_d     = io_write_value[1:0];
        default:  ctrl_d     = ctrl_q;
      endcase
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Register-file storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= 2'b01;
      baud_div_q <= 16'(CLKS_PER_BIT);
      ovf_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      baud_div_q <= baud_div_d;
      ovf_q      <= ovf_d;
    end
  end

  // FSM state register, including the datapath that moves with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    if (state_q == ST_IDLE) begin
      baud_cnt_d = 16'd0;
    end else if (bit_end_s) begin
      baud_cnt_d = 16'd0;
    end else begin
      baud_cnt_d = baud_cnt_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_START;
          shift_d = fifo_dout_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; tx is registered from the next state so it changes on the same edge as the state.
  always_comb begin
    fifo_pop_s = 1'b0;
    tx_d       = 1'b1;
    if ((state_q == ST_IDLE) && start_s) begin
      fifo_pop_s = 1'b1;
    end else begin
      fifo_pop_s = 1'b0;
    end
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Combinational read mux.
  always_comb begin
    status_s                              = 32'd0;
    status_s[STATUS_BUSY_BIT]             = (state_q != ST_IDLE);
    status_s[STATUS_FULL_BIT]             = fifo_full_s;
    status_s[STATUS_EMPTY_BIT]            = fifo_empty_s;
    status_s[STATUS_OVF_BIT]              = ovf_q;
    status_s[STATUS_COUNT_LSB +: 8]       = 8'(fifo_count_s);
    rdata_s                               = 32'd0;
    if (io_read_en) begin
      case (reg_idx_s)
        REG_STATUS: rdata_s = status_s;
        REG_BAUD:   rdata_s = {16'd0, baud_div_q};
        REG_CTRL:   rdata_s = {30'd0, ctrl_q};
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign io_read_value = rdata_s;
  assign tx            = tx_q;
  assign irq           = ctrl_q[CTRL_IRQ_EN_BIT] && fifo_empty_s;

endmodule
